// File: rtl/sobel_window_ctrl_if.sv
// Handshake bundle between the pixel source and the Sobel window controller.
//   i_pixel_valid : source -> ctrl, one pixel written to the current write line buffer
//   o_wr_sel      : ctrl -> buffers, index of the line buffer being written
//   o_rd_sel      : ctrl -> buffers, top line of the 3-line read window
//   o_rd_en       : ctrl -> buffers, read strobe for the three window buffers
//   o_mux_ctrl    : ctrl -> output mux, 1 passes the Sobel pixel, 0 forces zero
//   o_line_req    : ctrl -> source, pulse: a line buffer was freed
//   o_frame_done  : ctrl -> consumer, pulse: last output row of the frame was read
interface sobel_window_ctrl_if;
    logic       i_pixel_valid;
    logic [1:0] o_wr_sel;
    logic [1:0] o_rd_sel;
    logic       o_rd_en;
    logic       o_mux_ctrl;
    logic       o_line_req;
    logic       o_frame_done;

    // Source side (pixel producer / testbench).
    modport master (
        output i_pixel_valid,
        input  o_wr_sel,
        input  o_rd_sel,
        input  o_rd_en,
        input  o_mux_ctrl,
        input  o_line_req,
        input  o_frame_done
    );

    // Controller side.
    modport slave (
        input  i_pixel_valid,
        output o_wr_sel,
        output o_rd_sel,
        output o_rd_en,
        output o_mux_ctrl,
        output o_line_req,
        output o_frame_done
    );
endinterface

// File: rtl/sobel_window_ctrl.sv
// Line-buffer controller for a 3x3 Sobel window over four rotating line buffers.
// Incoming pixels fill one buffer at a time; once three complete lines are held, a
// row of IMG_W pixels is read from the 3-line window and the oldest line is freed.
// At the end of a frame the whole window is dropped so the next frame starts clean.
// Ports:
//   i_clk   : sole clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : sobel_window_ctrl_if.slave (pixel strobe in, buffer selects/strobes out)
module sobel_window_ctrl #(
    parameter int unsigned IMG_W = 512,
    parameter int unsigned IMG_H = 512
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    sobel_window_ctrl_if.slave bus
);

    localparam int unsigned PW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic {StIdle, StRead} state_e;

    state_e        state_q;
    logic [PW-1:0] wr_pix_q;
    logic [PW-1:0] rd_pix_q;
    logic [RW-1:0] out_row_q;
    logic [2:0]    fill_q;
    logic [2:0]    fill_d;
    logic [1:0]    wr_sel_q;
    logic [1:0]    rd_sel_q;
    logic          rd_en_q;
    logic          mux_ctrl_q;
    logic          line_req_q;
    logic          frame_done_q;

    logic accept;
    logic wr_done;
    logic row_done;
    logic final_row;

    always_comb begin
        // With all four buffers occupied there is nowhere to put a pixel.
        accept    = bus.i_pixel_valid && (fill_q != 3'd4);
        wr_done   = accept && (wr_pix_q == PW'(IMG_W - 1));
        row_done  = (state_q == StRead) && (rd_pix_q == PW'(IMG_W - 1));
        final_row = row_done && (out_row_q == RW'(IMG_H - 3));
        // Write completion and release can coincide; apply the net change.
        fill_d = fill_q;
        if (wr_done) begin
            fill_d = fill_d + 3'd1;
        end
        if (row_done) begin
            fill_d = fill_d - (final_row ? 3'd3 : 3'd1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            wr_pix_q     <= '0;
            rd_pix_q     <= '0;
            out_row_q    <= '0;
            fill_q       <= '0;
            wr_sel_q     <= '0;
            rd_sel_q     <= '0;
            rd_en_q      <= 1'b0;
            mux_ctrl_q   <= 1'b0;
            line_req_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            fill_q       <= fill_d;
            line_req_q   <= row_done;
            frame_done_q <= final_row;
            // Line buffers return data one cycle after the read strobe.
            mux_ctrl_q   <= rd_en_q;

            if (accept) begin
                wr_pix_q <= wr_done ? '0 : wr_pix_q + PW'(1);
                if (wr_done) begin
                    wr_sel_q <= wr_sel_q + 2'd1;
                end
            end

            case (state_q)
                StIdle: begin
                    rd_pix_q <= '0;
                    if (fill_d >= 3'd3) begin
                        state_q <= StRead;
                        rd_en_q <= 1'b1;
                    end
                end
                StRead: begin
                    if (row_done) begin
                        state_q  <= StIdle;
                        rd_en_q  <= 1'b0;
                        rd_pix_q <= '0;
                        if (final_row) begin
                            // Drop the whole window: next frame starts three buffers on.
                            out_row_q <= '0;
                            rd_sel_q  <= rd_sel_q + 2'd3;
                        end else begin
                            out_row_q <= out_row_q + RW'(1);
                            rd_sel_q  <= rd_sel_q + 2'd1;
                        end
                    end else begin
                        rd_pix_q <= rd_pix_q + PW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_wr_sel     = wr_sel_q;
    assign bus.o_rd_sel     = rd_sel_q;
    assign bus.o_rd_en      = rd_en_q;
    assign bus.o_mux_ctrl   = mux_ctrl_q;
    assign bus.o_line_req   = line_req_q;
    assign bus.o_frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl with IMG_W = 4, IMG_H = 5.
// The driver pushes the cycle of every expected output event into per-output queues;
// a negedge monitor pops an entry whenever the DUT raises that output.
module tb_sobel_window_ctrl;

    localparam int unsigned W = 4;
    localparam int unsigned H = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sobel_window_ctrl_if bus();

    sobel_window_ctrl #(
        .IMG_W(W),
        .IMG_H(H)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int base     = 0;
    bit done     = 1'b0;

    typedef struct {
        int         cyc;
        logic [1:0] rd_sel;
        logic [1:0] wr_sel;
    } lr_t;

    int  q_rd[$];
    int  q_mux[$];
    int  q_fd[$];
    lr_t q_lr[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: output high at cycle %0d, none expected", name, cyc);
    endtask

    task automatic missing(input string name, input int c);
        checks++;
        failures++;
        $display("FAIL %s: expected at cycle %0d, never seen", name, c);
    endtask

    // Monitor: every high output must match the head of its queue.
    always @(negedge clk) begin
        if (!done) begin
            if (bus.o_rd_en === 1'b1) begin
                if (q_rd.size() == 0) unexpected("rd_en");
                else check("rd_en_cycle", cyc, q_rd.pop_front());
            end
            if (bus.o_mux_ctrl === 1'b1) begin
                if (q_mux.size() == 0) unexpected("mux_ctrl");
                else check("mux_ctrl_cycle", cyc, q_mux.pop_front());
            end
            if (bus.o_frame_done === 1'b1) begin
                if (q_fd.size() == 0) unexpected("frame_done");
                else check("frame_done_cycle", cyc, q_fd.pop_front());
            end
            if (bus.o_line_req === 1'b1) begin
                if (q_lr.size() == 0) begin
                    unexpected("line_req");
                end else begin
                    lr_t e;
                    e = q_lr.pop_front();
                    check("line_req_cycle", cyc, e.cyc);
                    check("rd_sel_at_release", bus.o_rd_sel, e.rd_sel);
                    check("wr_sel_at_release", bus.o_wr_sel, e.wr_sel);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int n);
        bus.i_pixel_valid = 1'b1;
        tick(n);
        bus.i_pixel_valid = 1'b0;
    endtask

    // Pixel strobe held high during reset; it must be ignored.
    task automatic do_reset(input int n);
        rst_n             = 1'b0;
        bus.i_pixel_valid = 1'b1;
        tick(n);
        rst_n             = 1'b1;
        bus.i_pixel_valid = 1'b0;
        base              = cyc;
    endtask

    task automatic idle_until(input int rel);
        if (base + rel > cyc) tick(base + rel - cyc);
    endtask

    // A row whose first read strobe is at relative cycle s.
    task automatic push_row(input int s, input int rd_after, input int wr_after, input bit fin);
        lr_t e;
        for (int i = 0; i < int'(W); i++) begin
            q_rd.push_back(base + s + i);
            q_mux.push_back(base + s + i + 1);
        end
        e.cyc    = base + s + int'(W);
        e.rd_sel = rd_after[1:0];
        e.wr_sel = wr_after[1:0];
        q_lr.push_back(e);
        if (fin) q_fd.push_back(base + s + int'(W));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_rd_en"},      bus.o_rd_en,      0);
        check({tag, "_mux_ctrl"},   bus.o_mux_ctrl,   0);
        check({tag, "_line_req"},   bus.o_line_req,   0);
        check({tag, "_frame_done"}, bus.o_frame_done, 0);
        check({tag, "_wr_sel"},     bus.o_wr_sel,     0);
        check({tag, "_rd_sel"},     bus.o_rd_sel,     0);
    endtask

    initial begin
        bus.i_pixel_valid = 1'b0;

        // Reset for two cycles.
        do_reset(2);
        check_cleared("reset");

        // Three lines then one row: release frees buffer 0.
        push_row(12, 1, 3, 1'b0);
        send(12);
        check("wr_sel_after_12px", bus.o_wr_sel, 3);
        check("rd_en_after_12px", bus.o_rd_en, 1);
        idle_until(24);

        // Reset during the second READ cycle aborts the row without a release.
        do_reset(2);
        check_cleared("reset2");
        q_rd.push_back(base + 12);
        q_rd.push_back(base + 13);
        q_mux.push_back(base + 13);
        send(12);
        tick(1);
        rst_n             = 1'b0;
        bus.i_pixel_valid = 1'b1;
        tick(1);
        check_cleared("mid_read_reset");
        rst_n             = 1'b1;
        bus.i_pixel_valid = 1'b0;
        base              = cyc;
        // Counters must be back at zero: same timing as a fresh start.
        push_row(12, 1, 3, 1'b0);
        send(12);
        idle_until(24);

        // Two frames back to back. Line 4 completes on the first release edge,
        // frame 2 lines are written during frame 1's final row, and one pixel
        // offered while all four buffers are full is dropped.
        do_reset(2);
        push_row(12, 1, 0, 1'b0);
        push_row(17, 2, 1, 1'b0);
        push_row(22, 1, 2, 1'b1);
        push_row(34, 2, 1, 1'b0);
        push_row(39, 3, 2, 1'b0);
        push_row(44, 2, 2, 1'b1);
        send(20);
        tick(1);
        send(4);
        send(1);
        send(8);
        send(8);
        idle_until(60);
        check("final_wr_sel", bus.o_wr_sel, 2);
        check("final_rd_sel", bus.o_rd_sel, 2);
        check("final_rd_en", bus.o_rd_en, 0);

        done = 1'b1;
        while (q_rd.size() > 0)  missing("rd_en", q_rd.pop_front());
        while (q_mux.size() > 0) missing("mux_ctrl", q_mux.pop_front());
        while (q_fd.size() > 0)  missing("frame_done", q_fd.pop_front());
        while (q_lr.size() > 0) begin
            lr_t e;
            e = q_lr.pop_front();
            missing("line_req", e.cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
